// File: rtl/mul_acc.sv
// mul_acc: serial unsigned multiply-accumulate, p = a*b + c.
//
// One multiplier bit is consumed per clock into a 64-bit accumulator that
// starts at the zero-extended addend, so every operation takes exactly 33
// clocks from the start strobe to the completion pulse, whatever the operands.
// A start strobe in any state aborts the operation in flight and restarts.
//
// Ports
//   clk   - clock, all state changes on the rising edge
//   rst   - asynchronous active-high reset
//   en    - start strobe; loads a, b, c and begins a new operation
//   a     - unsigned multiplicand (WIDTH bits)
//   b     - unsigned multiplier (WIDTH bits)
//   c     - unsigned addend (WIDTH bits)
//   p     - registered result a*b+c (2*WIDTH bits), held until next completion
//   ov    - registered flag: upper WIDTH bits of p are non-zero
//   done  - one-cycle completion pulse
//   busy  - high while an operation is in progress
module mul_acc #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [WIDTH-1:0]     c,
    output logic [2*WIDTH-1:0]   p,
    output logic                 ov,
    output logic                 done,
    output logic                 busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t                 state_r, state_s;
    logic [2*WIDTH-1:0]     acc_r, acc_s;
    logic [WIDTH-1:0]       a_r, a_s;
    logic [WIDTH-1:0]       b_r, b_s;
    logic [CW-1:0]          cnt_r, cnt_s;
    logic [2*WIDTH-1:0]     p_s;
    logic                   ov_s;
    logic                   done_s;
    logic                   busy_s;
    logic [2*WIDTH-1:0]     a_shift_s;

    // Multiplicand aligned to the weight of the multiplier bit being consumed.
    assign a_shift_s = {{WIDTH{1'b0}}, a_r} << cnt_r;

    // Next-state and datapath update; en overrides whatever state we are in.
    always_comb begin
        state_s = state_r;
        acc_s   = acc_r;
        a_s     = a_r;
        b_s     = b_r;
        cnt_s   = cnt_r;
        p_s     = p;
        ov_s    = ov;
        done_s  = 1'b0;
        busy_s  = busy;

        if (en) begin
            a_s     = a;
            b_s     = b;
            acc_s   = {{WIDTH{1'b0}}, c};
            cnt_s   = {CW{1'b0}};
            busy_s  = 1'b1;
            state_s = RUN;
        end else begin
            case (state_r)
                IDLE: begin
                    busy_s = 1'b0;
                end
                RUN: begin
                    if (b_r[cnt_r]) begin
                        acc_s = acc_r + a_shift_s;
                    end else begin
                        acc_s = acc_r;
                    end
                    cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_r == CW'(WIDTH - 1)) begin
                        state_s = FIN;
                    end else begin
                        state_s = RUN;
                    end
                end
                FIN: begin
                    p_s     = acc_r;
                    ov_s    = |acc_r[2*WIDTH-1:WIDTH];
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                    state_s = IDLE;
                end
                default: begin
                    busy_s  = 1'b0;
                    state_s = IDLE;
                end
            endcase
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            acc_r   <= {(2*WIDTH){1'b0}};
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
            p       <= {(2*WIDTH){1'b0}};
            ov      <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_r <= state_s;
            acc_r   <= acc_s;
            a_r     <= a_s;
            b_r     <= b_s;
            cnt_r   <= cnt_s;
            p       <= p_s;
            ov      <= ov_s;
            done    <= done_s;
            busy    <= busy_s;
        end
    end

endmodule

// File: doc/mul_acc.md
MUL_ACC -- requirements
Module: mul_acc

Interface
REQ-001 Parameter WIDTH SHALL default to 32 and set the operand width; all widths below use WIDTH=32.
REQ-002 Port clk SHALL be an input of width 1: the single clock; all state changes on its rising edge.
REQ-003 Port rst SHALL be an input of width 1: reset, asynchronous and active-high.
REQ-004 Port en SHALL be an input of width 1: start strobe; on a sampled-high edge, operands load and a new operation begins.
REQ-005 Port a SHALL be an input of width 32: unsigned multiplicand (e.g. quotient from the divider).
REQ-006 Port b SHALL be an input of width 32: unsigned multiplier (e.g. divisor).
REQ-007 Port c SHALL be an input of width 32: unsigned addend (e.g. remainder).
REQ-008 Port p SHALL be an output reg of width 64: result a*b+c.
REQ-009 Port ov SHALL be an output reg of width 1: high when p[63:32] != 0 (result does not fit 32 bits).
REQ-010 Port done SHALL be an output reg of width 1: one-cycle completion pulse.
REQ-011 Port busy SHALL be an output reg of width 1: high while an operation is in progress.

Function
REQ-012 Arithmetic SHALL be unsigned; p = a*b + c exactly, no truncation (max 2^64-2^32 fits 64 bits).
REQ-013 FSM SHALL have states IDLE, RUN, FIN; reset state IDLE.
REQ-014 Method SHALL be serial shift-add: one multiplier bit per clock, 64-bit accumulator initialised to zero-extended c.
REQ-015 Edge E0 with en=1 (any state): latch a,b; acc<=c; cnt<=0; busy<=1; done<=0; state<=RUN.
REQ-016 RUN, edges E1..E32: if b bit cnt is 1, acc<=acc+(a<<cnt); cnt<=cnt+1; at edge with cnt=31, state<=FIN.
REQ-017 FIN, edge E33: p<=acc; ov<=|acc[63:32]; done<=1; busy<=0; state<=IDLE.
REQ-018 Latency SHALL be fixed at 33 clocks from en edge to done edge, independent of operand values (no early exit on b=0).
REQ-019 done SHALL be high for exactly one cycle per completed operation, then return to 0.
REQ-020 p and ov SHALL hold the last completed result until the next completion; they SHALL NOT change during RUN.
REQ-021 en SHALL have priority over all states: en in RUN or FIN aborts the current operation, discards its result, and restarts per REQ-015; the aborted operation SHALL produce no done pulse.
REQ-022 en held high continuously SHALL keep reloading; done SHALL not assert until 33 edges after the last en-high edge.
REQ-023 busy SHALL be 0 whenever done is 1.

Reset
REQ-024 rst=1 SHALL immediately (no clock edge) force state=IDLE, p=0, ov=0, done=0, busy=0, acc=0, cnt=0.
REQ-025 While rst=1, en SHALL be ignored; the first operation starts on the first en-high edge after rst deasserts.
REQ-026 rst asserted mid-RUN SHALL abandon the operation with no done pulse.

Verification
REQ-027 a=7, b=6, c=3, en one cycle -> done pulse at 33rd edge, p=45, ov=0, busy high edges 1..32.
REQ-028 a=b=c=0xFFFFFFFF -> p=0xFFFFFFFF_00000000, ov=1, done after 33 edges.
REQ-029 Divider inverse: a=14285, b=7, c=5 -> p=100000 (0x186A0), ov=0.
REQ-030 a=0x12345678, b=0, c=9 -> p=9, ov=0, done still at 33rd edge.
REQ-031 en with a=3,b=5,c=0, then en at edge 10 with a=2,b=2,c=1 -> exactly one done, 33 edges after second en, p=5.
REQ-032 rst pulse at edge 15 of an operation -> p=0, done=0, busy=0 asynchronously; no done follows; subsequent a=4,b=4,c=0 gives p=16.
